mix_column_sb_param: RTL and testbench



---
 rtl/mix_column_sb_param.sv | 176 +++++++++++++++++
 tb/tb_mix_column_sb_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_sb_param.sv
// PASTA mix-column (L'=2L+R, R'=L+2R) followed by an optional S-box (none/Feistel/cube),
// sequenced over shared modadd/modmul units. Define MCSB_SKIP_MC_EN to add skip_mc (bypass MC).
module mix_column_sb_param #(
  parameter int BITLEN   = 17,
  parameter int PASTA_S  = 32,
  parameter int PIPE_ADD = 3,
  parameter int PIPE_MUL = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                sb_mode,
`ifdef MCSB_SKIP_MC_EN
  input  logic                      skip_mc,
`endif
  input  logic [BITLEN*PASTA_S-1:0] in_l,
  input  logic [BITLEN*PASTA_S-1:0] in_r,
  input  logic [BITLEN*PASTA_S-1:0] modadd_out,
  input  logic [BITLEN*PASTA_S-1:0] modmul_out,
  output logic [BITLEN*PASTA_S-1:0] modadd_in1,
  output logic [BITLEN*PASTA_S-1:0] modadd_in2,
  output logic [BITLEN*PASTA_S-1:0] modmul_in1,
  output logic [BITLEN*PASTA_S-1:0] modmul_in2,
  output logic                      modadd_issue,
  output logic                      modmul_issue,
  output logic [BITLEN*PASTA_S-1:0] out_l,
  output logic [BITLEN*PASTA_S-1:0] out_r,
  output logic                      busy,
  output logic                      done
);

  localparam int W  = BITLEN * PASTA_S;
  localparam int CW = $clog2(2 * (PIPE_ADD + PIPE_MUL) + 4);

  localparam logic [CW-1:0] C_A   = CW'(PIPE_ADD);
  localparam logic [CW-1:0] C_A1  = CW'(PIPE_ADD + 1);
  localparam logic [CW-1:0] C_2A  = CW'(2 * PIPE_ADD);
  localparam logic [CW-1:0] C_2A1 = CW'(2 * PIPE_ADD + 1);
  localparam logic [CW-1:0] C_M   = CW'(PIPE_MUL);
  localparam logic [CW-1:0] C_M1  = CW'(PIPE_MUL + 1);
  localparam logic [CW-1:0] C_2M  = CW'(2 * PIPE_MUL);
  localparam logic [CW-1:0] C_2M1 = CW'(2 * PIPE_MUL + 1);
  localparam logic [CW-1:0] C_MA  = CW'(PIPE_MUL + PIPE_ADD);
  localparam logic [CW-1:0] C_MA1 = CW'(PIPE_MUL + PIPE_ADD + 1);

  typedef enum logic [1:0] {IDLE, MC, SB, DONE} state_t;
  typedef enum logic [1:0] {SB_NONE, SB_FEI, SB_CUBE} sbox_t;

  state_t          state, state_nx;
  sbox_t           mode_q;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    sum_q;
  logic            cap_l, cap_r, cap_mul;

  // Move lane k-1 into lane k; lane 0 (MSB) becomes zero.
  function automatic logic [W-1:0] shr(input logic [W-1:0] x);
    return {{BITLEN{1'b0}}, x[W-1:BITLEN]};
  endfunction

  assign busy = (state == MC) || (state == SB);
  assign done = (state == DONE);

  always_comb begin
    state_nx     = state;
    modadd_issue = 1'b0;
    modmul_issue = 1'b0;
    modadd_in1   = '0;
    modadd_in2   = '0;
    modmul_in1   = '0;
    modmul_in2   = '0;
    cap_l        = 1'b0;
    cap_r        = 1'b0;
    cap_mul      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MCSB_SKIP_MC_EN
          state_nx = skip_mc ? SB : MC;
`else
          state_nx = MC;
`endif
        end
      end
      MC: begin
        if (cnt == '0) begin
          modadd_issue = 1'b1; modadd_in1 = out_l; modadd_in2 = out_r;
        end
        // S is forwarded straight from the unit on the cycle it appears.
        if (cnt == C_A) begin
          modadd_issue = 1'b1; modadd_in1 = modadd_out; modadd_in2 = out_l;
        end
        if (cnt == C_A1) begin
          modadd_issue = 1'b1; modadd_in1 = sum_q; modadd_in2 = out_r;
        end
        if (cnt == C_2A) cap_l = 1'b1;
        if (cnt == C_2A1) begin
          cap_r    = 1'b1;
          state_nx = (mode_q == SB_NONE) ? DONE : SB;
        end
      end
      SB: begin
        case (mode_q)
          SB_CUBE: begin
            cap_mul = 1'b1;
            if (cnt == '0) begin
              modmul_issue = 1'b1; modmul_in1 = out_l; modmul_in2 = out_l;
            end
            if (cnt == CW'(1)) begin
              modmul_issue = 1'b1; modmul_in1 = out_r; modmul_in2 = out_r;
            end
            if (cnt == C_M) begin
              modmul_issue = 1'b1; modmul_in1 = modmul_out; modmul_in2 = out_l;
            end
            if (cnt == C_M1) begin
              modmul_issue = 1'b1; modmul_in1 = modmul_out; modmul_in2 = out_r;
            end
            if (cnt == C_2M) cap_l = 1'b1;
            if (cnt == C_2M1) begin
              cap_r    = 1'b1;
              state_nx = DONE;
            end
          end
          SB_FEI: begin
            if (cnt == '0) begin
              modmul_issue = 1'b1; modmul_in1 = out_l; modmul_in2 = out_l;
            end
            if (cnt == CW'(1)) begin
              modmul_issue = 1'b1; modmul_in1 = out_r; modmul_in2 = out_r;
            end
            if (cnt == C_M) begin
              modadd_issue = 1'b1; modadd_in1 = out_l; modadd_in2 = shr(modmul_out);
            end
            if (cnt == C_M1) begin
              modadd_issue = 1'b1; modadd_in1 = out_r; modadd_in2 = shr(modmul_out);
            end
            if (cnt == C_MA) cap_l = 1'b1;
            if (cnt == C_MA1) begin
              cap_r    = 1'b1;
              state_nx = DONE;
            end
          end
          default: state_nx = DONE;
        endcase
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      out_l  <= '0;
      out_r  <= '0;
      sum_q  <= '0;
      mode_q <= SB_NONE;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + CW'(1);
      if (state == IDLE && start) begin
        out_l <= in_l;
        out_r <= in_r;
        case (sb_mode)
          2'd1:    mode_q <= SB_FEI;
          2'd2:    mode_q <= SB_CUBE;
          default: mode_q <= SB_NONE;
        endcase
      end
      if (state == MC && cnt == C_A) sum_q <= modadd_out;
      if (cap_l) out_l <= cap_mul ? modmul_out : modadd_out;
      if (cap_r) out_r <= cap_mul ? modmul_out : modadd_out;
    end
  end

endmodule

// File: tb/tb_mix_column_sb_param.sv
// Bench for mix_column_sb_param: pipelined mod-65537 unit models, lane-level reference
// model with spec-derived schedule, and a per-cycle compare process.
module tb_mix_column_sb_param;
  localparam int A = 3;
  localparam int M = 4;
  localparam int S = 32;
  localparam int B = 17;
  localparam int W = B * S;
  localparam longint unsigned Q = 65537;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [1:0]   sb_mode;
`ifdef MCSB_SKIP_MC_EN
  logic         skip_mc;
`endif
  logic [W-1:0] in_l, in_r, modadd_out, modmul_out;
  logic [W-1:0] modadd_in1, modadd_in2, modmul_in1, modmul_in2, out_l, out_r;
  logic         modadd_issue, modmul_issue, busy, done;

  always #5 clk = ~clk;

  mix_column_sb_param #(.BITLEN(B), .PASTA_S(S), .PIPE_ADD(A), .PIPE_MUL(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sb_mode(sb_mode),
`ifdef MCSB_SKIP_MC_EN
    .skip_mc(skip_mc),
`endif
    .in_l(in_l), .in_r(in_r), .modadd_out(modadd_out), .modmul_out(modmul_out),
    .modadd_in1(modadd_in1), .modadd_in2(modadd_in2),
    .modmul_in1(modmul_in1), .modmul_in2(modmul_in2),
    .modadd_issue(modadd_issue), .modmul_issue(modmul_issue),
    .out_l(out_l), .out_r(out_r), .busy(busy), .done(done));

  function automatic longint unsigned lane(input logic [W-1:0] v, input int k);
    return 64'(v[W-1-B*k -: B]);
  endfunction

  function automatic logic [W-1:0] vop(input logic [W-1:0] x, input logic [W-1:0] y, input bit mul);
    logic [W-1:0] res;
    longint unsigned v;
    res = '0;
    for (int k = 0; k < S; k++) begin
      v = mul ? (lane(x, k) * lane(y, k)) % Q : (lane(x, k) + lane(y, k)) % Q;
      res[W-1-B*k -: B] = B'(v);
    end
    return res;
  endfunction

  // Shared unit models: result valid exactly A / M cycles after the operands.
  logic [W-1:0] add_pipe [A];
  logic [W-1:0] mul_pipe [M];
  always @(posedge clk) begin
    add_pipe[0] <= vop(modadd_in1, modadd_in2, 1'b0);
    mul_pipe[0] <= vop(modmul_in1, modmul_in2, 1'b1);
    for (int i = 1; i < A; i++) add_pipe[i] <= add_pipe[i-1];
    for (int i = 1; i < M; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign modadd_out = add_pipe[A-1];
  assign modmul_out = mul_pipe[M-1];

  function automatic logic [W-1:0] splat(input longint unsigned v);
    logic [W-1:0] res;
    for (int k = 0; k < S; k++) res[W-1-B*k -: B] = B'(v);
    return res;
  endfunction

  function automatic logic [W-1:0] mkvec(input longint unsigned seed);
    logic [W-1:0] res;
    for (int k = 0; k < S; k++) res[W-1-B*k -: B] = B'((seed * longint'(k + 1) * 7919 + longint'(k) * 131) % Q);
    return res;
  endfunction

  // Reference: lane-wise mix then S-box, straight from the algebra.
  function automatic void model(input logic [W-1:0] l, input logic [W-1:0] r, input logic [1:0] mode,
                                input bit skip, output logic [W-1:0] ol, output logic [W-1:0] orr);
    longint unsigned ml [S];
    longint unsigned mr [S];
    longint unsigned yl, yr;
    for (int k = 0; k < S; k++) begin
      ml[k] = skip ? lane(l, k) : (2 * lane(l, k) + lane(r, k)) % Q;
      mr[k] = skip ? lane(r, k) : (lane(l, k) + 2 * lane(r, k)) % Q;
    end
    for (int k = 0; k < S; k++) begin
      yl = ml[k];
      yr = mr[k];
      if (mode == 2'd2) begin
        yl = ((ml[k] * ml[k]) % Q) * ml[k] % Q;
        yr = ((mr[k] * mr[k]) % Q) * mr[k] % Q;
      end else if (mode == 2'd1 && k > 0) begin
        yl = (ml[k] + (ml[k-1] * ml[k-1]) % Q) % Q;
        yr = (mr[k] + (mr[k-1] * mr[k-1]) % Q) % Q;
      end
      ol[W-1-B*k -: B]  = B'(yl);
      orr[W-1-B*k -: B] = B'(yr);
    end
  endfunction

  // Issue cycles and done cycle relative to the start cycle c0.
  function automatic void sched(input logic [1:0] mode, input bit skip, output int lat,
                                output longint unsigned am, output longint unsigned mm);
    int s0;
    am = 0; mm = 0;
    s0 = skip ? 1 : 3 + 2 * A;
    if (!skip) am = (64'd1 << 1) | (64'd1 << (1 + A)) | (64'd1 << (2 + A));
    if (mode == 2'd2) begin
      mm = (64'd1 << s0) | (64'd1 << (s0 + 1)) | (64'd1 << (s0 + M)) | (64'd1 << (s0 + M + 1));
      lat = s0 + 2 * M + 2;
    end else if (mode == 2'd1) begin
      mm = (64'd1 << s0) | (64'd1 << (s0 + 1));
      am = am | (64'd1 << (s0 + M)) | (64'd1 << (s0 + M + 1));
      lat = s0 + M + A + 2;
    end else begin
      lat = skip ? s0 + 1 : s0;
    end
  endfunction

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  bit              active = 1'b0;
  int              k = 0;
  int              lat = 0;
  int              abort_k = 0;
  longint unsigned add_mask, mul_mask;
  logic [W-1:0]    exp_l, exp_r;

  always @(negedge clk) begin
    if (active && k >= 1) begin
      if (abort_k > 0 && k == abort_k + 1) begin
        chk("abort_out_l", out_l, '0);
        chk("abort_out_r", out_r, '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_issue", W'({modadd_issue, modmul_issue}), '0);
        chk("abort_ops", modadd_in1 | modadd_in2 | modmul_in1 | modmul_in2, '0);
      end else begin
        chk("busy", W'(busy), W'(k < lat));
        chk("done", W'(done), W'(k == lat));
        chk("add_issue", W'(modadd_issue), W'(add_mask[k]));
        chk("mul_issue", W'(modmul_issue), W'(mul_mask[k]));
        if (!modadd_issue) chk("add_ops_idle", modadd_in1 | modadd_in2, '0);
        if (!modmul_issue) chk("mul_ops_idle", modmul_in1 | modmul_in2, '0);
        if (k == lat || k == lat + 1) begin
          chk("out_l", out_l, exp_l);
          chk("out_r", out_r, exp_r);
        end
      end
    end
  end

  // Called at posedge+#1 with the DUT idle; returns at posedge+#1 with the DUT idle.
  task automatic run(input logic [W-1:0] l, input logic [W-1:0] r, input logic [1:0] mode,
                     input bit skip, input int ign1, input int ign2, input int abort_at);
    int stop;
    model(l, r, mode, skip, exp_l, exp_r);
    sched(mode, skip, lat, add_mask, mul_mask);
    abort_k = abort_at;
    in_l = l; in_r = r; sb_mode = mode;
`ifdef MCSB_SKIP_MC_EN
    skip_mc = skip;
`endif
    start = 1'b1; k = 0; active = 1'b1;
    stop = (abort_at > 0) ? abort_at + 1 : lat + 1;
    @(posedge clk); #1;
    for (int c = 1; c <= stop; c++) begin
      k = c;
      start = (c == ign1 || c == ign2);
      rst_n = !(abort_at > 0 && c == abort_at);
      if (c == 1) begin
        in_l = ~l; in_r = ~r; sb_mode = ~mode;
`ifdef MCSB_SKIP_MC_EN
        skip_mc = ~skip;
`endif
      end
      @(posedge clk); #1;
    end
    active = 1'b0; start = 1'b0; rst_n = 1'b1; abort_k = 0;
  endtask

  logic [W-1:0] fei_lit;

  initial begin
    rst_n = 1'b0; start = 1'b1; sb_mode = 2'd2;
    in_l = mkvec(3); in_r = mkvec(5);
`ifdef MCSB_SKIP_MC_EN
    skip_mc = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_l", out_l, '0);
    chk("rst_out_r", out_r, '0);
    chk("rst_busy_done", W'({busy, done}), '0);
    chk("rst_issue", W'({modadd_issue, modmul_issue}), '0);
    chk("rst_ops", modadd_in1 | modadd_in2 | modmul_in1 | modmul_in2, '0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(splat(1), splat(2), 2'd0, 1'b0, -1, -1, 0);
    chk("lit_m0_l", out_l, splat(4));
    chk("lit_m0_r", out_r, splat(5));

    run(splat(1), splat(1), 2'd2, 1'b0, -1, -1, 0);
    chk("lit_cube_l", out_l, splat(27));
    chk("lit_cube_r", out_r, splat(27));

    run(splat(1), splat(1), 2'd1, 1'b0, -1, -1, 0);
    fei_lit = splat(12);
    fei_lit[W-1 -: B] = B'(3);
    chk("lit_fei_l", out_l, fei_lit);
    chk("lit_fei_r", out_r, fei_lit);

    run(splat(65536), splat(65536), 2'd0, 1'b0, 3, 9, 0);
    chk("lit_wrap_l", out_l, splat(65534));
    chk("lit_wrap_r", out_r, splat(65534));

    run(mkvec(11), mkvec(23), 2'd3, 1'b0, -1, -1, 0);
    run(mkvec(7), mkvec(13), 2'd2, 1'b0, 5, -1, 0);
    run(mkvec(17), mkvec(29), 2'd1, 1'b0, -1, -1, 0);

    run(splat(1), splat(1), 2'd2, 1'b0, -1, -1, 3 + 2 * A + 2);
    run(splat(1), splat(2), 2'd0, 1'b0, -1, -1, 0);
    chk("lit_after_abort_l", out_l, splat(4));
    chk("lit_after_abort_r", out_r, splat(5));

`ifdef MCSB_SKIP_MC_EN
    run(splat(2), splat(2), 2'd2, 1'b1, -1, -1, 0);
    chk("lit_skip_cube", out_l & out_r, splat(8));
    run(mkvec(19), mkvec(31), 2'd0, 1'b1, -1, -1, 0);
    chk("lit_skip_pass", out_l, mkvec(19));
    run(mkvec(41), mkvec(43), 2'd1, 1'b1, -1, -1, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", passed, total);
    $fatal(1);
  end

endmodule
